// File: rtl/interval_timer_param.sv
// Interval timer: a free-running down-counter with a 16-bit register bus and a level irq.
// Optional build macro TIMER_SNAPSHOT_EN adds counter snapshot registers at addresses 4/5.
module interval_timer_param #(
    parameter int unsigned COUNTER_WIDTH = 32,            // 17..32
    parameter logic [31:0] RESET_PERIOD  = 32'h02FAF07F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int unsigned HI_W = COUNTER_WIDTH - 16;
    localparam logic [COUNTER_WIDTH-1:0] RESET_VAL = RESET_PERIOD[COUNTER_WIDTH-1:0];

    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic                     run_q, run_d;
    logic                     to_q, to_d;
    logic                     ito_q, ito_d;
    logic                     cont_q, cont_d;
    logic [15:0]              readdata_q, readdata_d;
    logic [15:0]              snap_lo, snap_hi;

    logic wr_en;
    logic wr_status, wr_control, wr_periodl, wr_periodh, wr_period;
    logic zero_reload, timeout;

    assign wr_en      = chipselect & ~write_n;
    assign wr_status  = wr_en && (address == ADDR_STATUS);
    assign wr_control = wr_en && (address == ADDR_CONTROL);
    assign wr_periodl = wr_en && (address == ADDR_PERIODL);
    assign wr_periodh = wr_en && (address == ADDR_PERIODH);
    assign wr_period  = wr_periodl | wr_periodh;

    // A period write reloads the counter itself, so it suppresses the zero-reload timeout.
    assign zero_reload = run_q && (counter_q == '0);
    assign timeout     = zero_reload & ~wr_period;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        period_d = period_q;
        if (wr_periodl) period_d[15:0] = writedata;
        if (wr_periodh) period_d[COUNTER_WIDTH-1:16] = writedata[HI_W-1:0];
    end

    always_comb begin
        counter_d = counter_q;
        if (wr_period) begin
            counter_d = period_d;
        end else if (zero_reload) begin
            counter_d = period_q;
        end else if (run_q) begin
            counter_d = counter_q - COUNTER_WIDTH'(1);
        end
    end

    // A timeout sets TO after any clear, so a coincident status write cannot lose it.
    always_comb begin
        to_d = to_q;
        if (wr_status) to_d = 1'b0;
        if (timeout)   to_d = 1'b1;
    end

    // STOP is applied last so it wins over START and over a continuous-mode restart.
    always_comb begin
        run_d  = run_q;
        ito_d  = ito_q;
        cont_d = cont_q;
        if (timeout) run_d = cont_q;
        if (wr_control) begin
            ito_d  = writedata[0];
            cont_d = writedata[1];
            if (writedata[2]) run_d = 1'b1;
            if (writedata[3]) run_d = 1'b0;
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;
    logic        wr_snap;

    assign wr_snap = wr_en && ((address == ADDR_SNAPL) || (address == ADDR_SNAPH));

    always_comb begin
        snap_d = snap_q;
        if (wr_snap) snap_d = 32'(counter_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_lo = snap_q[15:0];
    assign snap_hi = snap_q[31:16];
`else
    assign snap_lo = '0;
    assign snap_hi = '0;
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS:  readdata_d = {14'b0, run_q, to_q};
            ADDR_CONTROL: readdata_d = {14'b0, cont_q, ito_q};
            ADDR_PERIODL: readdata_d = period_q[15:0];
            ADDR_PERIODH: readdata_d = 16'(period_q[COUNTER_WIDTH-1:16]);
            ADDR_SNAPL:   readdata_d = snap_lo;
            ADDR_SNAPH:   readdata_d = snap_hi;
            default:      readdata_d = '0;
        endcase
    end

    // NOTE: reset is synchronous, so it only acts on a rising edge; holding reset_n low
    // between edges changes nothing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter_q  <= RESET_VAL;
            period_q   <= RESET_VAL;
            run_q      <= 1'b0;
            to_q       <= 1'b0;
            ito_q      <= 1'b0;
            cont_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            // NOTE: state uses <= so every register samples the same pre-edge values.
            counter_q  <= counter_d;
            period_q   <= period_d;
            run_q      <= run_d;
            to_q       <= to_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = to_q & ito_q;

endmodule

// File: tb/tb_interval_timer_param.sv
// Scoreboard bench for interval_timer_param at COUNTER_WIDTH=26; expectations are queued
// as stimulus is driven and popped when the matching output is sampled on the falling edge.
module tb_interval_timer_param;

    localparam int CW     = 26;
    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    interval_timer_param #(.COUNTER_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int vectors     = 0;
    int miscompares = 0;

`ifdef TIMER_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    // Every task starts and ends just after a falling edge; a bus access takes one rising edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] q);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        q          = readdata;
        chipselect = 1'b0;
    endtask

    // Rising edges until irq is seen high; BUDGET means it never came.
    task automatic cycles_to_irq(output int n);
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (irq) break;
        end
    endtask

    task automatic test_reset;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        logic [15:0] exp_rd [8] = '{16'h0000, 16'h0000, 16'hF07F, 16'h02FA,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.push_back('{"reset readdata", 32'h0});
        sb_q.push_back('{"reset irq", 32'h0});
        for (int i = 0; i < 2; i++) begin
            obs = (i == 0) ? 32'(readdata) : 32'(irq);
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            sb_q.push_back('{$sformatf("reset read addr%0d", a), 32'(exp_rd[a])});
            rd(3'(a), q);
            e = sb_q.pop_front();
            vectors++;
            if (32'(q) !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, q, e.exp);
            end
        end
    endtask

    task automatic test_registers;
        logic [15:0] q;
        sb_entry_t   e;
        logic [2:0]  ra [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        logic [15:0] re [6] = '{16'h0000, 16'h0003, 16'hABCD, 16'h03FF, 16'h0000, 16'h0000};
        wr(3'd1, 16'hFFF3);
        wr(3'd2, 16'hABCD);
        wr(3'd3, 16'hFFFF);
        wr(3'd6, 16'hFFFF);
        wr(3'd7, 16'hFFFF);
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{$sformatf("reg read addr%0d", ra[i]), 32'(re[i])});
            rd(ra[i], q);
            e = sb_q.pop_front();
            vectors++;
            if (32'(q) !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, q, e.exp);
            end
        end
        wr(3'd1, 16'h0000);
    endtask

    task automatic test_periodic;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        int          n;
        wr(3'd2, 16'd9);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        for (int step = 0; step < 6; step++) begin
            case (step)
                0: begin
                    sb_q.push_back('{"periodic first interval", 32'd10});
                    wr(3'd1, 16'h0007);
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
                1: begin
                    sb_q.push_back('{"periodic status", 32'h3});
                    rd(3'd0, q);
                    obs = 32'(q);
                end
                2: begin
                    sb_q.push_back('{"irq after status clear", 32'h0});
                    wr(3'd0, 16'd0);
                    obs = 32'(irq);
                end
                3: begin
                    sb_q.push_back('{"periodic next timeout", 32'd8});
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
                4: begin
                    repeat (9) @(negedge clk);
                    sb_q.push_back('{"clear coincident with timeout", 32'h1});
                    wr(3'd0, 16'd0);
                    obs = 32'(irq);
                end
                default: begin
                    wr(3'd1, 16'h0008);
                    sb_q.push_back('{"status after stop", 32'h1});
                    rd(3'd0, q);
                    obs = 32'(q);
                end
            endcase
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        wr(3'd0, 16'd0);
    endtask

    task automatic test_oneshot;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        int          n;
        wr(3'd2, 16'd4);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        for (int step = 0; step < 5; step++) begin
            case (step)
                0: begin
                    sb_q.push_back('{"oneshot interval", 32'd5});
                    wr(3'd1, 16'h0005);
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
                1: begin
                    sb_q.push_back('{"oneshot status", 32'h1});
                    rd(3'd0, q);
                    obs = 32'(q);
                end
                2: begin
                    sb_q.push_back('{"oneshot control", 32'h1});
                    rd(3'd1, q);
                    obs = 32'(q);
                end
                3: begin
                    wr(3'd0, 16'd0);
                    sb_q.push_back('{"oneshot extra irqs", 32'd0});
                    n = 0;
                    repeat (15) begin
                        @(negedge clk);
                        if (irq) n++;
                    end
                    obs = 32'(n);
                end
                default: begin
                    sb_q.push_back('{"oneshot restart interval", 32'd5});
                    wr(3'd1, 16'h0005);
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
            endcase
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0000);
    endtask

    task automatic test_start_stop;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        int          n;
        wr(3'd2, 16'd20);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0005);
        repeat (4) @(negedge clk);
        wr(3'd1, 16'h000C);
        repeat (10) @(negedge clk);
        for (int step = 0; step < 3; step++) begin
            case (step)
                0: begin
                    sb_q.push_back('{"start+stop status", 32'h0});
                    rd(3'd0, q);
                    obs = 32'(q);
                end
                1: begin
                    sb_q.push_back('{"start+stop irq", 32'h0});
                    obs = 32'(irq);
                end
                default: begin
                    sb_q.push_back('{"held counter interval", 32'd16});
                    wr(3'd1, 16'h0005);
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
            endcase
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0000);
    endtask

    task automatic test_zero_period;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        wr(3'd2, 16'd0);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0007);
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                @(negedge clk);
                sb_q.push_back('{"zero period irq", 32'h1});
                obs = 32'(irq);
            end else if (k < 4) begin
                sb_q.push_back('{$sformatf("zero period irq after clear %0d", k), 32'h1});
                wr(3'd0, 16'd0);
                obs = 32'(irq);
            end else if (k == 4) begin
                sb_q.push_back('{"zero period status", 32'h3});
                rd(3'd0, q);
                obs = 32'(q);
            end else begin
                wr(3'd1, 16'h0008);
                wr(3'd0, 16'd0);
                sb_q.push_back('{"zero period stopped status", 32'h0});
                rd(3'd0, q);
                obs = 32'(q);
            end
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back_period_write;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        int          n;
        wr(3'd2, 16'd3);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0007);
        repeat (3) @(negedge clk);
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: begin
                    sb_q.push_back('{"period write over reload irq", 32'h0});
                    wr(3'd2, 16'd6);
                    obs = 32'(irq);
                end
                1: begin
                    sb_q.push_back('{"interval after period write", 32'd7});
                    cycles_to_irq(n);
                    obs = 32'(n);
                end
                2: begin
                    sb_q.push_back('{"status after period write", 32'h3});
                    rd(3'd0, q);
                    obs = 32'(q);
                end
                default: begin
                    sb_q.push_back('{"periodl after write", 32'h6});
                    rd(3'd2, q);
                    obs = 32'(q);
                end
            endcase
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        wr(3'd1, 16'h0008);
        wr(3'd0, 16'd0);
    endtask

    task automatic test_snapshot;
        logic [15:0] q;
        sb_entry_t   e;
        wr(3'd2, 16'h2345);
        wr(3'd3, 16'h0001);
        wr(3'd4, 16'h0000);
        for (int a = 4; a < 6; a++) begin
            sb_q.push_back('{$sformatf("snapshot addr%0d", a),
                             SNAP ? ((a == 4) ? 32'h2345 : 32'h0001) : 32'h0});
            rd(3'(a), q);
            e = sb_q.pop_front();
            vectors++;
            if (32'(q) !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, q, e.exp);
            end
        end
    endtask

    task automatic test_reset_midcount;
        logic [15:0] q;
        logic [31:0] obs;
        sb_entry_t   e;
        int          n;
        logic [2:0]  ra [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        wr(3'd2, 16'd5);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        sb_q.push_back('{"pre-reset interval", 32'd6});
        wr(3'd1, 16'h0007);
        cycles_to_irq(n);
        e = sb_q.pop_front();
        vectors++;
        if (32'(n) !== e.exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, n, e.exp);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back('{"midcount reset readdata", 32'h0});
        sb_q.push_back('{"midcount reset irq", 32'h0});
        for (int i = 0; i < 2; i++) begin
            obs = (i == 0) ? 32'(readdata) : 32'(irq);
            e = sb_q.pop_front();
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, obs, e.exp);
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 4) wr(3'd4, 16'h0000);
            case (i)
                2:       obs = 32'hF07F;
                3:       obs = 32'h02FA;
                4:       obs = SNAP ? 32'hF07F : 32'h0;
                5:       obs = SNAP ? 32'h02FA : 32'h0;
                default: obs = 32'h0;
            endcase
            sb_q.push_back('{$sformatf("midcount reset addr%0d", ra[i]), obs});
            rd(ra[i], q);
            e = sb_q.pop_front();
            vectors++;
            if (32'(q) !== e.exp) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, q, e.exp);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        @(negedge clk);
        test_reset;
        test_registers;
        test_periodic;
        test_oneshot;
        test_start_stop;
        test_zero_period;
        test_back_to_back_period_write;
        test_snapshot;
        test_reset_midcount;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/interval_timer_param.md
INTERVAL_TIMER_PARAM -- requirements
Module: interval_timer_param

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32: down-counter and period width, legal range 17..32.
REQ-002 SHALL have parameter RESET_PERIOD, default 32'h02FAF07F: period and counter value after reset, truncated to COUNTER_WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port address, input, 3: register select.
REQ-006 SHALL have port chipselect, input, 1: slave select.
REQ-007 SHALL have port write_n, input, 1: active-low write strobe.
REQ-008 SHALL have port writedata, input, 16: write data.
REQ-009 SHALL have port readdata, output, 16: registered read data.
REQ-010 SHALL have port irq, output, 1: interrupt request, level.

Function
REQ-011 SHALL decode a write as chipselect=1 and write_n=0, with these addresses: 0 status, 1 control, 2 periodl, 3 periodh, 4 snapl, 5 snaph; writes to 6..7 are ignored.
REQ-012 SHALL present on readdata, one cycle after the address is applied, the mux of: status {14'b0, RUN, TO}; control {12'b0, 2'b0, CONT, ITO}; periodl/periodh as the low/high 16 bits of period (zero-extended); snapl/snaph as the snapshot halves; 0 for 6..7.
REQ-013 SHALL form period as {periodh, periodl}[COUNTER_WIDTH-1:0].
REQ-014 SHALL store control bit0 as ITO and bit1 as CONT; bit2 (START) and bit3 (STOP) SHALL be write-only pulses that are not stored.
REQ-015 SHALL set RUN=1 on a control write with START=1, and RUN=0 on one with STOP=1; when both are set, STOP SHALL win.
REQ-016 SHALL, while RUN=1 and counter!=0, decrement the counter by 1 each cycle; while RUN=0 the counter SHALL hold.
REQ-017 SHALL, while RUN=1 and counter==0, on the next edge: load counter<=period, set TO=1, and set RUN<=CONT; the timeout interval is therefore period+1 cycles.
REQ-018 SHALL, on a periodl or periodh write, update that half and load the counter with the new full period on the next edge, with RUN unchanged and no timeout generated.
REQ-019 SHALL clear TO on any status write; if a timeout occurs in the same cycle, TO SHALL end at 1.
REQ-020 SHALL drive irq = TO & ITO combinationally from the registers, with no additional latency.
REQ-021 SHALL, when period==0 with CONT=1 and RUN=1, raise TO every cycle and keep the counter at 0.
REQ-022 SHALL let a period write win over a simultaneous zero-reload, which then generates no timeout.

Reset
REQ-023 SHALL, on a clock edge with reset_n=0, set: counter=RESET_PERIOD, period=RESET_PERIOD, RUN=0, TO=0, ITO=0, CONT=0, snapshot=0, readdata=0; irq SHALL therefore be 0.
REQ-024 SHALL apply reset even mid-count, and SHALL leave state unchanged while reset_n=0 is held between clock edges.

Configuration
REQ-025 SHALL, with macro TIMER_SNAPSHOT_EN defined, capture the current counter value into the snapshot register, zero-extended to 32 bits, on any write to address 4 or 5; snapl/snaph SHALL then read its halves.
REQ-026 SHALL, without TIMER_SNAPSHOT_EN, omit the snapshot register, make addresses 4 and 5 read 0, and ignore writes to them.

Verification
REQ-027 SHALL cover: periodl=9, periodh=0, then control=0x7 (ITO|CONT|START) -> TO and irq rise every 10 cycles; status read returns 0x0003.
REQ-028 SHALL cover: period=4, control=0x5 (one-shot) -> exactly one TO 5 cycles after start, RUN=0 afterwards, counter holding at 4.
REQ-029 SHALL cover: status write in the same cycle as a timeout -> TO stays 1; a status write on a later, non-timeout cycle -> TO and irq are 0 on the next cycle.
REQ-030 SHALL cover: control=0xC (START and STOP together) -> RUN=0 and the counter holds its value.
REQ-031 SHALL cover, with TIMER_SNAPSHOT_EN: counter=0x00012345, write to address 4 -> addr4 reads 0x2345 and addr5 reads 0x0001; without the macro, both read 0x0000.
REQ-032 SHALL cover: reset_n=0 for one edge mid-count at COUNTER_WIDTH=26 -> counter=0x2FAF07F, RUN=0, irq=0, and readdata=0 on the next cycle.
